// File: rtl/i2c_write_master_if.sv
// rtl/i2c_write_master_if.sv - core command and open-drain line bundle for i2c_write_master
interface i2c_write_master_if;
    logic        start;
    logic [6:0]  slave_addr;
    logic [15:0] wdata;
    logic        scl_in;
    logic        sda_in;
    logic        scl_oe;
    logic        sda_oe;
    logic        busy;
    logic        done;
    logic        ack_err;

    modport master (
        input  start, slave_addr, wdata, scl_in, sda_in,
        output scl_oe, sda_oe, busy, done, ack_err
    );

    modport slave (
        output start, slave_addr, wdata, scl_in, sda_in,
        input  scl_oe, sda_oe, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - write-only I2C master (START, addr+W, 2 data bytes, STOP); I2C_CLK_STRETCH_EN enables SCL stretching
module i2c_write_master #(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    i2c_write_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, SHIFT, ACK, STOP, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_d;
    logic [7:0]  div_cnt, div_cnt_d;
    logic [1:0]  quarter, quarter_d;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic [1:0]  frame, frame_d;
    logic [7:0]  shreg, shreg_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        ack_err_q, ack_err_d;
    logic        scl_q, scl_d, sda_q, sda_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        in_slot, q_end, stall, slot_end;

    assign in_slot  = (state == START) || (state == SHIFT) || (state == ACK) || (state == STOP);
    assign q_end    = (div_cnt == DIV_LAST);
    assign slot_end = q_end && (quarter == 2'd3);

`ifdef I2C_CLK_STRETCH_EN
    // A slave holding SCL low at the end of a released q1 freezes the quarter timer.
    assign stall = in_slot && (quarter == 2'd1) && q_end && !scl_q && !bus.scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = bus.scl_in;
    assign stall         = 1'b0;
`endif

    // Next-state, counter and shift logic; line outputs are derived from the next state so they register on the quarter's first clock.
    always_comb begin
        state_d   = state;
        div_cnt_d = div_cnt;
        quarter_d = quarter;
        bit_cnt_d = bit_cnt;
        frame_d   = frame;
        shreg_d   = shreg;
        addr_d    = addr_q;
        data_d    = data_q;
        ack_err_d = ack_err_q;
        scl_d     = 1'b0;
        sda_d     = 1'b0;

        if (in_slot && !stall) begin
            if (q_end) begin
                div_cnt_d = '0;
                quarter_d = quarter + 2'd1;
            end else begin
                div_cnt_d = div_cnt + 8'd1;
            end
        end

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d   = START;
                    addr_d    = bus.slave_addr;
                    data_d    = bus.wdata;
                    ack_err_d = 1'b0;
                    div_cnt_d = '0;
                    quarter_d = '0;
                    bit_cnt_d = '0;
                    frame_d   = '0;
                end
            end
            START: begin
                if (slot_end) begin
                    state_d   = SHIFT;
                    shreg_d   = {addr_q, 1'b0};
                    bit_cnt_d = '0;
                    frame_d   = '0;
                end
            end
            SHIFT: begin
                if (slot_end) begin
                    shreg_d   = {shreg[6:0], 1'b0};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if ((quarter == 2'd2) && q_end && bus.sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (slot_end) begin
                    if (ack_err_q || (frame == 2'd2)) begin
                        state_d = STOP;
                    end else begin
                        state_d   = SHIFT;
                        frame_d   = frame + 2'd1;
                        shreg_d   = (frame == 2'd0) ? data_q[15:8] : data_q[7:0];
                        bit_cnt_d = '0;
                    end
                end
            end
            STOP: begin
                if (slot_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START: begin
                scl_d = (quarter_d == 2'd3);
                sda_d = quarter_d[1];
            end
            SHIFT: begin
                scl_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
                sda_d = ~shreg_d[7];
            end
            ACK: begin
                scl_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
                sda_d = 1'b0;
            end
            STOP: begin
                scl_d = (quarter_d == 2'd0);
                sda_d = ~quarter_d[1];
            end
            default: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
        endcase

        busy_d = (state_d == START) || (state_d == SHIFT) || (state_d == ACK) || (state_d == STOP);
        done_d = (state_d == DONE);
    end

    // State, counters, captured command and registered line/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            quarter   <= '0;
            bit_cnt   <= '0;
            frame     <= '0;
            shreg     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            div_cnt   <= div_cnt_d;
            quarter   <= quarter_d;
            bit_cnt   <= bit_cnt_d;
            frame     <= frame_d;
            shreg     <= shreg_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.scl_oe  = scl_q;
    assign bus.sda_oe  = sda_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
endmodule

// File: tb/tb_i2c_write_master.sv
// tb/tb_i2c_write_master.sv - randomized model-checked bench for i2c_write_master
module tb_i2c_write_master;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        start_r = 1'b0;
    logic [6:0]  addr_r = '0;
    logic [15:0] wdata_r = '0;
    logic        sel = 1'b0;
    logic        pull = 1'b0;
    logic        hold = 1'b0;
    logic        chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_write_master_if bus4 ();
    i2c_write_master_if bus1 ();

    assign bus4.start      = start_r & ~sel;
    assign bus4.slave_addr = addr_r;
    assign bus4.wdata      = wdata_r;
    assign bus4.scl_in     = ~bus4.scl_oe & ~hold;
    assign bus4.sda_in     = ~bus4.sda_oe & ~(pull & ~sel);
    assign bus1.start      = start_r & sel;
    assign bus1.slave_addr = addr_r;
    assign bus1.wdata      = wdata_r;
    assign bus1.scl_in     = ~bus1.scl_oe;
    assign bus1.sda_in     = ~bus1.sda_oe & ~(pull & sel);

    i2c_write_master #(.CLK_DIV(4)) u4 (.clk(clk), .reset(reset), .bus(bus4));
    i2c_write_master #(.CLK_DIV(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));

    logic m_scl, m_sda, m_busy, m_done, m_aerr;
    assign m_scl  = sel ? bus1.scl_oe  : bus4.scl_oe;
    assign m_sda  = sel ? bus1.sda_oe  : bus4.sda_oe;
    assign m_busy = sel ? bus1.busy    : bus4.busy;
    assign m_done = sel ? bus1.done    : bus4.done;
    assign m_aerr = sel ? bus1.ack_err : bus4.ack_err;

    // Expected per-cycle outputs of one transaction, index 0 = first cycle after the start strobe.
    bit e_scl[$], e_sda[$], e_busy[$], e_done[$], e_pull[$], e_aerr[$];
    int mbase = 0;
    int mlen = 0;
    bit pre_aerr = 1'b0, post_aerr = 1'b0, run_aerr = 1'b0;
    bit hold_on = 1'b0;
    int hs = 0;

    int done_cnt = 0, done_cyc = 0;
    bit bits[$];
    bit prev_scl = 1'b0, seen_one = 1'b0;
    int run = 0, runs_n = 0, runs_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(bit s, bit d, bit b, bit dn, bit p, bit a);
        e_scl.push_back(s); e_sda.push_back(d); e_busy.push_back(b);
        e_done.push_back(dn); e_pull.push_back(p); e_aerr.push_back(a);
    endtask

    // One slot: scl/sda give the pulled-low pattern for quarters 0..3; ext lengthens q1.
    task automatic put_slot(bit [3:0] scl, bit [3:0] sda, bit p, int d, int ext, bit nack_here);
        int n;
        for (int q = 0; q < 4; q++) begin
            n = d + ((q == 1) ? ext : 0);
            if (nack_here && q == 3) run_aerr = 1'b1;
            for (int k = 0; k < n; k++) push(scl[q], sda[q], 1'b1, 1'b0, p, run_aerr);
        end
    endtask

    task automatic build(logic [6:0] a, logic [15:0] w, int nack_frame, int d, int st_slot, int st_len);
        logic [7:0] by;
        int slot;
        e_scl.delete(); e_sda.delete(); e_busy.delete();
        e_done.delete(); e_pull.delete(); e_aerr.delete();
        pre_aerr = post_aerr;
        run_aerr = 1'b0;
        put_slot(4'b1000, 4'b1100, 1'b0, d, 0, 1'b0);
        slot = 1;
        for (int f = 0; f < 3; f++) begin
            by = (f == 0) ? {a, 1'b0} : (f == 1) ? w[15:8] : w[7:0];
            for (int b = 7; b >= 0; b--) begin
                put_slot(4'b1001, {4{~by[b]}}, 1'b0, d, (slot == st_slot) ? st_len : 0, 1'b0);
                slot++;
            end
            put_slot(4'b1001, 4'b0000, f != nack_frame, d, (slot == st_slot) ? st_len : 0, f == nack_frame);
            slot++;
            if (f == nack_frame) break;
        end
        put_slot(4'b0001, 4'b0011, 1'b0, d, (slot == st_slot) ? st_len : 0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, run_aerr);
        post_aerr = run_aerr;
        mlen = e_scl.size();
    endtask

    // Compare DUT outputs against the model every cycle; also drives the model slave's ACK and stretch.
    always @(negedge clk) begin
        int i;
        bit es, ed, eb, edn, ea, ep;
        if (chk_en) begin
            i = cyc - mbase;
            if (i >= 0 && i < mlen) begin
                es = e_scl[i]; ed = e_sda[i]; eb = e_busy[i];
                edn = e_done[i]; ea = e_aerr[i]; ep = e_pull[i];
            end else begin
                es = 1'b0; ed = 1'b0; eb = 1'b0; edn = 1'b0; ep = 1'b0;
                ea = (i < 0) ? pre_aerr : post_aerr;
            end
            pull <= ep;
            hold <= hold_on && (cyc >= hs) && (cyc < hs + 20);
            chk("scl_oe", {31'd0, m_scl}, {31'd0, es});
            chk("sda_oe", {31'd0, m_sda}, {31'd0, ed});
            chk("busy", {31'd0, m_busy}, {31'd0, eb});
            chk("done", {31'd0, m_done}, {31'd0, edn});
            chk("ack_err", {31'd0, m_aerr}, {31'd0, ea});
        end
    end

    // Observe done pulses, the SDA value at each SCL release, and SCL-high run lengths.
    always @(negedge clk) begin
        if (m_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_scl && !m_scl) bits.push_back(~m_sda);
        prev_scl = m_scl;
        if (!m_scl) begin
            run++;
        end else begin
            if (run > 0 && seen_one) begin
                runs_n++;
                if (run != 2) runs_bad++;
            end
            run = 0;
            seen_one = 1'b1;
        end
    end

    function automatic logic [7:0] byte_at(int s);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[7-j] = (s + j < bits.size()) ? bits[s+j] : 1'b0;
        return r;
    endfunction

    task automatic run_txn(logic [6:0] a, logic [15:0] w, int nack_frame, int d, int st_slot, int st_len, output int c0);
        @(posedge clk); #1;
        c0 = cyc;
        build(a, w, nack_frame, d, st_slot, st_len);
        mbase = c0 + 1;
        addr_r = a;
        wdata_r = w;
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
    endtask

    task automatic wait_done(int c0, int exp_lat, string name);
        int n0, k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        chk(name, done_cyc - c0, exp_lat);
    endtask

    initial begin
        int c0, n0, nf, lat;
        logic [6:0] a;
        logic [15:0] w;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_scl", {31'd0, bus4.scl_oe}, 0);
        chk("rst_sda", {31'd0, bus4.sda_oe}, 0);
        chk("rst_busy", {31'd0, bus4.busy}, 0);
        chk("rst_done", {31'd0, bus4.done}, 0);
        chk("rst_ack_err", {31'd0, bus4.ack_err}, 0);
        chk("rst_busy_d1", {31'd0, bus1.busy}, 0);
        chk_en = 1'b1;

        bits.delete();
        run_txn(7'h50, 16'hA5C3, 3, 4, -1, 0, c0);
        chk("model_len_full", mlen, 465);
        wait_done(c0, 465, "latency_full");
        chk("byte0", byte_at(0), 8'hA0);
        chk("byte1", byte_at(9), 8'hA5);
        chk("byte2", byte_at(18), 8'hC3);
        chk("ack_err_full", {31'd0, m_aerr}, 0);

        bits.delete();
        run_txn(7'h3C, 16'h1111, 0, 4, -1, 0, c0);
        wait_done(c0, 177, "latency_nack");
        chk("ack_err_nack", {31'd0, m_aerr}, 1);
        chk("nack_bits", bits.size(), 10);
        run_txn(7'h11, 16'h2222, 3, 4, -1, 0, c0);
        repeat (3) @(negedge clk);
        chk("ack_err_cleared", {31'd0, m_aerr}, 0);
        wait_done(c0, 465, "latency_after_nack");

        bits.delete();
        n0 = done_cnt;
        run_txn(7'h2A, 16'h1234, 3, 4, -1, 0, c0);
        repeat (98) @(posedge clk);
        #1;
        addr_r = 7'h55;
        wdata_r = 16'hFFFF;
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        wait_done(c0, 465, "latency_midstart");
        repeat (20) @(negedge clk);
        chk("midstart_done_count", done_cnt - n0, 1);
        chk("midstart_byte0", byte_at(0), 8'h54);
        chk("midstart_byte1", byte_at(9), 8'h12);
        chk("midstart_byte2", byte_at(18), 8'h34);

        n0 = done_cnt;
        run_txn(7'h44, 16'hBEEF, 3, 4, -1, 0, c0);
        repeat (314) @(posedge clk);
        #1;
        reset = 1'b1;
        mlen = cyc + 1 - mbase;
        post_aerr = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_scl", {31'd0, bus4.scl_oe}, 0);
        chk("rst_mid_sda", {31'd0, bus4.sda_oe}, 0);
        chk("rst_mid_busy", {31'd0, bus4.busy}, 0);
        repeat (500) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - n0, 0);

        for (int t = 0; t < 8; t++) begin
            a = 7'($urandom_range(0, 127));
            w = 16'($urandom);
            nf = $urandom_range(0, 3);
            lat = 1 + 16 * ((nf == 3) ? 29 : 2 + 9 * (nf + 1));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            run_txn(a, w, nf, 4, -1, 0, c0);
            wait_done(c0, lat, "latency_random");
        end

`ifdef I2C_CLK_STRETCH_EN
        run_txn(7'h50, 16'hA5C3, 3, 4, 4, 20, c0);
        hs = c0 + 72;
        hold_on = 1'b1;
        wait_done(c0, 485, "latency_stretch");
        hold_on = 1'b0;
`endif

        @(posedge clk); #1;
        sel = 1'b1;
        post_aerr = 1'b0;
        seen_one = 1'b0;
        run = 0;
        runs_n = 0;
        runs_bad = 0;
        bits.delete();
        run_txn(7'h50, 16'hA5C3, 3, 1, -1, 0, c0);
        wait_done(c0, 117, "latency_div1");
        chk("div1_scl_high_runs", runs_n, 27);
        chk("div1_scl_high_bad", runs_bad, 0);
        chk("div1_byte2", byte_at(18), 8'hC3);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_write_master.md
# i2c_write_master

Write-only I2C master peripheral sitting directly downstream of the 16-bit RISC core's control/datapath pair. It consumes the core's peripheral command (a start strobe, a 7-bit slave address and a 16-bit data word) and serialises it on the I2C bus as one write transaction: START, address+W, data high byte, data low byte, STOP. Slave ACKs are checked on every byte. Completion and error status are returned to the core.

## Interface
- `CLK_DIV`, 4 — system clocks per SCL quarter-period; legal range 1..255.
- `clk` input 1 — system clock; all logic on rising edge.
- `reset` input 1 — synchronous, active-high; this is the core's `i2c_reset`.
- `start` input 1 — one-cycle command strobe; honoured only in IDLE.
- `slave_addr` input 7 — target address; captured on an accepted `start`.
- `wdata` input 16 — word to send, MSB first; captured on an accepted `start`.
- `scl_in` input 1 — sampled SCL line level.
- `sda_in` input 1 — sampled SDA line level.
- `scl_oe` output 1 — 1 pulls SCL low, 0 releases it (open-drain).
- `sda_oe` output 1 — 1 pulls SDA low, 0 releases it (open-drain).
- `busy` output 1 — transaction in progress.
- `done` output 1 — one-cycle pulse when the transaction ends.
- `ack_err` output 1 — sticky NACK flag; cleared on the next accepted `start`.

## Operation
- States: IDLE, START, SHIFT, ACK, STOP, DONE.
- Shift register (8 bits) is loaded per frame: frame 0 = `{slave_addr,1'b0}`, frame 1 = `wdata[15:8]`, frame 2 = `wdata[7:0]`.
- Slot timing: every slot (start, data bit, ack, stop) is 4 quarters q0..q3, and each quarter lasts `CLK_DIV` clocks.
- Data/ack slot:
  - q0: SCL low; SDA set to the bit (ACK slot: SDA released).
  - q1: SCL released.
  - q2: SCL high.
  - q3: SCL low.
- START slot: q0–q1 both lines released; q2 SDA low; q3 SCL low.
- STOP slot: q0 SDA low, SCL low; q1 SCL released; q2–q3 SDA released.
- ACK check: `sda_in` is sampled on the last clock of q2.
  - 1 = NACK: set `ack_err`, skip the remaining frames, go to STOP.
- Transitions:
  - IDLE→START on `start`.
  - START→SHIFT.
  - SHIFT→ACK after 8 bits.
  - ACK→SHIFT if ACK received and frames remain.
  - ACK→STOP after frame 2 or on NACK.
  - STOP→DONE.
  - DONE→IDLE after 1 clock.
- `start` while `busy`: ignored; the captured address and data are unchanged.
- Reset mid-transaction: the next clock returns to IDLE with both lines released. No STOP is generated; the bus recovers via the next START.

## Timing
- Reset values: `scl_oe`=0, `sda_oe`=0, `busy`=0, `done`=0, `ack_err`=0; state IDLE; counters 0.
- Let T be the cycle where `start` is sampled in IDLE.
- `busy` rises at T+1.
- A full transaction is 29 slots.
- `done`=1 and `busy`=0 at cycle T+1+116·`CLK_DIV`. With `CLK_DIV`=4 this is T+465.
- NACK on the address frame: 11 slots, so `done` at T+1+44·`CLK_DIV`.
- `done` is exactly one cycle wide.
- A new `start` is accepted at the earliest on the cycle after `done`.
- Line outputs are registered; a change takes effect on the first clock of its quarter.

## Configuration
- `I2C_CLK_STRETCH_EN` defined:
  - At the end of every q1 in which SCL was released, the quarter counter holds while `scl_in`=0.
  - q2 starts on the first cycle `scl_in`=1.
  - Latency grows by exactly the stretch duration.
- Undefined: `scl_in` is ignored and timing is fixed as above.

## Test plan
- Address 0x50, `wdata`=0xA5C3, slave ACKs every byte, `CLK_DIV`=4:
  - SDA bit stream is 0xA0, 0xA5, 0xC3.
  - `done` at T+465, `ack_err`=0.
- Address 0x3C, `sda_in` held high during the address ACK:
  - STOP follows directly.
  - `done` at T+177, `ack_err`=1.
  - The next accepted `start` clears `ack_err`.
- `start` pulsed mid-transaction with different address/data:
  - Bus stream unchanged.
  - Only one `done` pulse.
- `reset` asserted during the second data frame:
  - Next cycle `scl_oe`=`sda_oe`=`busy`=0.
  - No `done` pulse.
- With `I2C_CLK_STRETCH_EN`, hold `scl_in` low for 20 clocks during bit 3 of the address: `done` at T+485.
- `CLK_DIV`=1, full ACKed write: `done` at T+117, and each SCL high phase is 2 clocks.
